// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and default requester count.
package uart_pkg;

    localparam int c_byte_w          = 8;
    localparam int c_default_num_req = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } tx_state_e;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request found when
// scanning upward from i_ptr (wrapping) wins a one-hot grant.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int p_num_req = c_default_num_req,
    localparam int c_ptr_w   = $clog2(p_num_req)
) (
    input  logic [p_num_req-1:0] i_req,
    input  logic [c_ptr_w-1:0]   i_ptr,
    output logic [p_num_req-1:0] o_grant
);

    int   idx;
    logic found;

    // Scan from the pointer, wrapping modulo p_num_req, and grant the first hit.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < p_num_req; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= p_num_req) begin
                idx = idx - p_num_req;
            end
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between several byte-stream requesters.
// Whole packets are kept together: once a requester wins, it keeps the
// transmitter until it sends a byte flagged last, or until it stays silent
// for p_hold_timeout cycles between bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int p_num_req      = c_default_num_req,
    parameter int p_hold_timeout = 50_000
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [p_num_req-1:0]                i_req_valid,
    input  logic [p_num_req-1:0][c_byte_w-1:0]  i_req_data,
    input  logic [p_num_req-1:0]                i_req_last,
    output logic [p_num_req-1:0]                o_req_ready,
    output logic                                o_tx_start,
    output logic [c_byte_w-1:0]                 o_tx_data,
    input  logic                                i_tx_done,
    output logic [p_num_req-1:0]                o_grant,
    output logic                                o_busy
);

    localparam int c_ptr_w = $clog2(p_num_req);
    localparam int c_cnt_w = $clog2(p_hold_timeout + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max    = c_cnt_w'(p_hold_timeout);
    localparam logic [c_cnt_w-1:0] c_cnt_expire = c_cnt_w'(p_hold_timeout - 1);
    localparam logic [c_ptr_w-1:0] c_last_idx   = c_ptr_w'(p_num_req - 1);

    tx_state_e state_q, state_d;

    logic [c_byte_w-1:0]  tx_data_q;
    logic                 last_q;
    logic [p_num_req-1:0] grant_q;
    logic [c_ptr_w-1:0]   owner_q;
    logic [c_ptr_w-1:0]   ptr_q;
    logic [c_cnt_w-1:0]   hold_cnt_q;

    logic [p_num_req-1:0] rr_grant;
    logic [p_num_req-1:0] req_ready;
    logic [p_num_req-1:0] held_valid;
    logic                 xfer;
    logic                 release_lock;
    logic                 hold_enter;
    logic [c_byte_w-1:0]  sel_data;
    logic                 sel_last;
    logic [c_ptr_w-1:0]   sel_idx;

    rr_arbiter #(
        .p_num_req (p_num_req)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_q),
        .o_grant (rr_grant)
    );

    assign held_valid = grant_q & i_req_valid;

    // Next-state logic, handshake and control strobes for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        o_tx_start   = 1'b0;
        xfer         = 1'b0;
        release_lock = 1'b0;
        hold_enter   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = rr_grant;
                if (|i_req_valid) begin
                    xfer    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (last_q) begin
                        release_lock = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        hold_enter = 1'b1;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                req_ready = held_valid;
                if (|held_valid) begin
                    xfer    = 1'b1;
                    state_d = S_START;
                end else if (hold_cnt_q == c_cnt_expire) begin
                    release_lock = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Nobody may see an accept while the block is held in reset.
    assign o_req_ready = i_rst ? req_ready : '0;

    // Pick out the byte and last flag of the requester being accepted.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < p_num_req; i++) begin
            if (req_ready[i]) begin
                sel_data = i_req_data[i];
                sel_last = i_req_last[i];
                sel_idx  = c_ptr_w'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture accepted bytes and track ownership plus the round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_data_q <= '0;
            last_q    <= 1'b0;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
        end else begin
            if (xfer) begin
                tx_data_q <= sel_data;
                last_q    <= sel_last;
                grant_q   <= req_ready;
                owner_q   <= sel_idx;
            end
            if (release_lock) begin
                grant_q <= '0;
                ptr_q   <= (owner_q == c_last_idx) ? '0 : owner_q + 1'b1;
            end
        end
    end

    // Count idle cycles while a packet lock is held; saturates at the limit.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_cnt_q <= '0;
        end else if (hold_enter || xfer) begin
            hold_cnt_q <= '0;
        end else if (state_q == S_HOLD && hold_cnt_q != c_cnt_max) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
        end
    end

    assign o_tx_data = tx_data_q;
    assign o_grant   = grant_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed packet scenarios, a transaction-level
// model checked every cycle, and literal expectations on the start log.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int T     = 20;  // hold timeout used for this bench
    localparam int FRAME = 6;   // cycles from start pulse to done pulse

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     i_req_valid;
    logic [N-1:0][7:0] i_req_data;
    logic [N-1:0]     i_req_last;
    logic [N-1:0]     o_req_ready;
    logic             o_tx_start;
    logic [7:0]       o_tx_data;
    logic             i_tx_done;
    logic [N-1:0]     o_grant;
    logic             o_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .p_num_req      (N),
        .p_hold_timeout (T)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_done   (i_tx_done),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester byte sources: {last, data} entries, consumed on handshake.
    logic [8:0] src_mem [N][8];
    int         src_head [N];
    int         src_tail [N];

    // Model of the arbiter as owner/lock bookkeeping.
    int         m_owner;     // -1 when nobody owns the transmitter
    bit         m_start_due; // a byte was accepted last cycle
    bit         m_wait;      // byte on the wire, waiting for done
    bit         m_hold;      // packet lock held between bytes
    bit         m_last;
    logic [7:0] m_data;
    int         m_ptr;
    int         m_idle;

    // UART emulation.
    int uart_cnt;
    bit extra_done;

    // Log of every start pulse seen on the DUT.
    logic [7:0]   log_data [$];
    logic [N-1:0] log_grant [$];
    int           log_cyc [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_tail[r]] = {l, d};
        src_tail[r]++;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_release();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_hold  = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        logic [N-1:0] v;
        logic [N-1:0] exp_ready;
        int           w;
        for (int i = 0; i < N; i++) begin
            v[i]          = (src_head[i] < src_tail[i]);
            i_req_data[i] = v[i] ? src_mem[i][src_head[i]][7:0] : 8'h00;
            i_req_last[i] = v[i] ? src_mem[i][src_head[i]][8] : 1'b0;
        end
        i_req_valid = v;
        i_tx_done   = (uart_cnt == 1) || extra_done;
        extra_done  = 1'b0;
        #1;
        exp_ready = '0;
        w         = -1;
        if (m_owner < 0) begin
            w = rr_pick(v, m_ptr);
        end else if (m_hold && v[m_owner]) begin
            w = m_owner;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", o_req_ready, exp_ready);
        check("ready_onehot0", $onehot0(o_req_ready), 1);
        check("tx_start", o_tx_start, m_start_due);
        check("tx_data", o_tx_data, m_data);
        check("grant", o_grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("busy", o_busy, m_owner >= 0);
        if (o_tx_start) begin
            log_data.push_back(o_tx_data);
            log_grant.push_back(o_grant);
            log_cyc.push_back(cyc);
        end
        if (w >= 0) begin
            m_owner     = w;
            m_data      = i_req_data[w];
            m_last      = i_req_last[w];
            m_start_due = 1'b1;
            m_hold      = 1'b0;
            src_head[w]++;
        end else if (m_start_due) begin
            m_start_due = 1'b0;
            m_wait      = 1'b1;
        end else if (m_wait) begin
            if (i_tx_done) begin
                m_wait = 1'b0;
                if (m_last) begin
                    model_release();
                end else begin
                    m_hold = 1'b1;
                    m_idle = 0;
                end
            end
        end else if (m_hold) begin
            m_idle++;
            if (m_idle == T) model_release();
        end
        if (uart_cnt > 0) uart_cnt--;
        if (o_tx_start) uart_cnt = FRAME;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        i_req_valid = '1;
        i_req_data  = '0;
        i_req_last  = '0;
        i_tx_done   = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        uart_cnt    = 0;
        extra_done  = 1'b0;
        m_owner     = -1;
        m_start_due = 1'b0;
        m_wait      = 1'b0;
        m_hold      = 1'b0;
        m_last      = 1'b0;
        m_data      = 8'h00;
        m_ptr       = 0;
        m_idle      = 0;
        log_data.delete();
        log_grant.delete();
        log_cyc.delete();
        #1;
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_req_ready, 0);
        @(negedge clk);
        check("rst_hold_ready", o_req_ready, 0);
        check("rst_hold_busy", o_busy, 0);
        @(negedge clk);
        i_req_valid = '0;
        rst_n       = 1'b1;
    endtask

    task automatic run_until(input int n_log, input int budget, input string name);
        int k = 0;
        while (log_data.size() < n_log && k < budget) begin
            step();
            k++;
        end
        check({name, "_reached"}, log_data.size() >= n_log, 1);
    endtask

    task automatic check_log(input int i, input logic [7:0] d, input logic [N-1:0] g, input string name);
        if (i >= log_data.size()) begin
            check({name, "_missing"}, log_data.size(), i + 1);
        end else begin
            check({name, "_data"}, log_data[i], d);
            check({name, "_grant"}, log_grant[i], g);
        end
    endtask

    task automatic check_gap(input int i, input int gap, input string name);
        if (i + 1 >= log_cyc.size()) begin
            check({name, "_missing"}, log_cyc.size(), i + 2);
        end else begin
            check(name, log_cyc[i + 1] - log_cyc[i], gap);
        end
    endtask

    initial begin
        int c0;
        rst_n       = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        i_tx_done   = 1'b0;
        @(negedge clk);
        do_reset();

        // Single byte from req0: start one cycle after acceptance.
        c0 = cyc;
        push(0, 8'hA5, 1'b1);
        run_until(1, 20, "single");
        check_log(0, 8'hA5, 4'b0001, "single");
        if (log_cyc.size() > 0) check("single_latency", log_cyc[0] - c0, 1);
        repeat (10) step();
        check("single_idle_busy", o_busy, 0);
        // Stray done while idle must be ignored.
        extra_done = 1'b1;
        repeat (4) step();

        // Fairness: every requester holds single-byte packets.
        do_reset();
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1);
        push(3, 8'h13, 1'b1);
        push(0, 8'h20, 1'b1);
        run_until(5, 200, "fair");
        check_log(0, 8'h10, 4'b0001, "fair0");
        check_log(1, 8'h11, 4'b0010, "fair1");
        check_log(2, 8'h12, 4'b0100, "fair2");
        check_log(3, 8'h13, 4'b1000, "fair3");
        check_log(4, 8'h20, 4'b0001, "fair4");
        check_gap(0, FRAME + 2, "fair_gap");

        // Packet lock: req1 sends three bytes while req2 waits.
        do_reset();
        push(1, 8'h01, 1'b0);
        push(1, 8'h02, 1'b0);
        push(1, 8'h03, 1'b1);
        push(2, 8'h77, 1'b1);
        run_until(4, 200, "lock");
        check_log(0, 8'h01, 4'b0010, "lock0");
        check_log(1, 8'h02, 4'b0010, "lock1");
        check_log(2, 8'h03, 4'b0010, "lock2");
        check_log(3, 8'h77, 4'b0100, "lock3");
        check_gap(1, FRAME + 2, "lock_gap");
        repeat (10) step();

        // Timeout: req3 goes silent mid-packet; req0 is served after release.
        do_reset();
        push(3, 8'h33, 1'b0);
        run_until(1, 20, "tmo_first");
        push(0, 8'h44, 1'b1);
        run_until(2, T + 60, "tmo_second");
        check_log(0, 8'h33, 4'b1000, "tmo0");
        check_log(1, 8'h44, 4'b0001, "tmo1");
        // start, FRAME cycles to done, T hold cycles, idle accept, start
        check_gap(0, T + FRAME + 2, "tmo_gap");
        repeat (10) step();

        // Reset during the wait of a two-byte packet abandons it.
        do_reset();
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b1);
        run_until(1, 20, "rst_first");
        check_log(0, 8'hB1, 4'b0010, "rst_b1");
        step();
        check("rst_in_wait_busy", o_busy, 1);
        do_reset();
        repeat (30) step();
        check("rst_no_second_start", log_data.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a run that never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_arbiter
